// File: rtl/lzc_rr_arbiter.sv
// Rotating-priority valid/ready arbiter with a one-entry registered output stage.
// Define LZC_RR_ARB_FAIR_EN for round-robin priority; otherwise the lowest index wins.

// Zero counter over a request vector; MODE 0 counts trailing zeros, MODE 1 leading zeros.
module lzc #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned CNT_WIDTH = 2,
  parameter bit          MODE      = 1'b0
) (
  input  logic [WIDTH-1:0]     i_in,
  output logic [CNT_WIDTH-1:0] o_cnt
);

  // All-zero input yields 0; callers qualify with their own "any" term.
  always_comb begin
    o_cnt = '0;
    if (MODE == 1'b0) begin
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
        if (i_in[i]) o_cnt = CNT_WIDTH'(i);
      end
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (i_in[i]) o_cnt = CNT_WIDTH'(int'(WIDTH) - 1 - i);
      end
    end
  end

endmodule

module lzc_rr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IDX_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          gnt_valid_o,
  input  logic                          gnt_ready_i,
  output logic [DATA_WIDTH-1:0]         gnt_data_o,
  output logic [IDX_WIDTH-1:0]          gnt_idx_o
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_data;
  logic [IDX_WIDTH-1:0]  r_idx;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic [IDX_WIDTH-1:0]  w_sel;
  logic [NUM_REQ-1:0]    w_lzc_in;
  logic                  w_any;
  logic                  w_can_load;
  logic                  w_accept;

`ifdef LZC_RR_ARB_FAIR_EN
  logic [IDX_WIDTH-1:0] r_prio;
  logic [IDX_WIDTH-1:0] w_sel_inc;
  logic [NUM_REQ-1:0]   w_mask;
  logic [NUM_REQ-1:0]   w_masked;

  // Requests at or above the priority pointer go first; fall back to the full vector on wrap.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      w_mask[i] = (IDX_WIDTH'(i) >= r_prio);
    end
  end

  assign w_masked  = req_valid_i & w_mask;
  assign w_lzc_in  = (|w_masked) ? w_masked : req_valid_i;
  assign w_sel_inc = (w_sel == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : w_sel + IDX_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio <= '0;
    end else if (w_accept) begin
      r_prio <= w_sel_inc;
    end
  end
`else
  assign w_lzc_in = req_valid_i;
`endif

  lzc #(
    .WIDTH     (NUM_REQ),
    .CNT_WIDTH (IDX_WIDTH),
    .MODE      (1'b0)
  ) u_lzc (
    .i_in  (w_lzc_in),
    .o_cnt (w_sel)
  );

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (w_sel == IDX_WIDTH'(i)) w_sel_data = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Flush beats both accept and drain; a held beat presented during flush is void.
  always_comb begin
    w_state_nxt = r_state;
    req_ready_o = '0;
    w_any       = |req_valid_i;
    w_can_load  = ((r_state == S_EMPTY) || gnt_ready_i) && !flush_i && !rst;
    w_accept    = w_any && w_can_load;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      req_ready_o[i] = w_accept && (w_sel == IDX_WIDTH'(i));
    end
    if (flush_i) begin
      w_state_nxt = S_EMPTY;
    end else if (w_accept) begin
      w_state_nxt = S_FULL;
    end else if ((r_state == S_FULL) && gnt_ready_i) begin
      w_state_nxt = S_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
      r_idx  <= '0;
    end else if (w_accept) begin
      r_data <= w_sel_data;
      r_idx  <= w_sel;
    end
  end

  assign gnt_valid_o = (r_state == S_FULL);
  assign gnt_data_o  = r_data;
  assign gnt_idx_o   = r_idx;

endmodule

// File: tb/tb_lzc_rr_arbiter.sv
// Directed table-driven bench for lzc_rr_arbiter (4-way) plus a 1-way pipeline sequence.
module tb_lzc_rr_arbiter;

`ifdef LZC_RR_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [3:0]  valid;
  logic [3:0]  ready;
  logic        gvalid;
  logic        gready;
  logic [31:0] gdata;
  logic [1:0]  gidx;
  logic [31:0] dat [4];
  logic [127:0] data_flat;

  logic        u1_valid;
  logic        u1_ready;
  logic        u1_gvalid;
  logic        u1_gready;
  logic [31:0] u1_data;
  logic [31:0] u1_gdata;
  logic        u1_gidx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign data_flat = {dat[3], dat[2], dat[1], dat[0]};

  lzc_rr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .req_valid_i (valid),
    .req_data_i  (data_flat),
    .req_ready_o (ready),
    .gnt_valid_o (gvalid),
    .gnt_ready_i (gready),
    .gnt_data_o  (gdata),
    .gnt_idx_o   (gidx)
  );

  lzc_rr_arbiter #(.NUM_REQ(1), .DATA_WIDTH(32)) dut1 (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (1'b0),
    .req_valid_i (u1_valid),
    .req_data_i  (u1_data),
    .req_ready_o (u1_ready),
    .gnt_valid_o (u1_gvalid),
    .gnt_ready_i (u1_gready),
    .gnt_data_o  (u1_gdata),
    .gnt_idx_o   (u1_gidx)
  );

  typedef struct {
    logic       rst;
    logic       flush;
    logic [3:0] valid;
    logic       gr;
    logic [3:0] exp_rr;
    logic       exp_gv;
    logic [1:0] exp_idx;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic f, input logic [3:0] v, input logic g,
                     input logic [3:0] rr, input logic gv, input logic [1:0] idx);
    vec_t e;
    e.rst = r; e.flush = f; e.valid = v; e.gr = g;
    e.exp_rr = rr; e.exp_gv = gv; e.exp_idx = idx;
    tbl.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  initial begin
    dat[0] = 32'h0000_0010;
    dat[1] = 32'h1111_1111;
    dat[2] = 32'hA5A5_A5A5;
    dat[3] = 32'h3333_3333;
    rst = 1'b1; flush = 1'b0; valid = 4'b1111; gready = 1'b0;
    u1_valid = 1'b0; u1_data = '0; u1_gready = 1'b0;

    // rst, flush, valid, gready | req_ready, gnt_valid, gnt_idx
    // Full contention
    add(0, 0, 4'b1111, 1, 4'b0001, 0, 0);
    add(0, 0, 4'b1111, 1, FAIR ? 4'b0010 : 4'b0001, 1, 0);
    add(0, 0, 4'b1111, 1, FAIR ? 4'b0100 : 4'b0001, 1, FAIR ? 2'd1 : 2'd0);
    add(0, 0, 4'b1111, 1, FAIR ? 4'b1000 : 4'b0001, 1, FAIR ? 2'd2 : 2'd0);
    add(0, 0, 4'b1111, 1, 4'b0001,                  1, FAIR ? 2'd3 : 2'd0);
    add(0, 0, 4'b1111, 1, FAIR ? 4'b0010 : 4'b0001, 1, 0);
    add(0, 0, 4'b0000, 1, 4'b0000,                  1, FAIR ? 2'd1 : 2'd0);
    // Backpressure on a beat from index 2
    add(0, 0, 4'b1100, 0, 4'b0100, 0, 0);
    for (int k = 0; k < 5; k++) add(0, 0, 4'b1100, 0, 4'b0000, 1, 2);
    add(0, 0, 4'b1100, 1, FAIR ? 4'b1000 : 4'b0100, 1, 2);
    add(0, 0, 4'b0000, 1, 4'b0000,                  1, FAIR ? 2'd3 : 2'd2);
    // Wrap and skip
    add(0, 0, 4'b0100, 1, 4'b0100, 0, 0);
    add(0, 0, 4'b0101, 1, 4'b0001, 1, 2);
    add(0, 0, 4'b0101, 1, FAIR ? 4'b0100 : 4'b0001, 1, 0);
    add(0, 0, 4'b0000, 1, 4'b0000, 1, FAIR ? 2'd2 : 2'd0);
    // Flush with ready
    add(0, 0, 4'b0001, 1, 4'b0001, 0, 0);
    add(0, 1, 4'b0010, 1, 4'b0000, 1, 0);
    add(0, 0, 4'b0011, 1, FAIR ? 4'b0010 : 4'b0001, 0, 0);
    add(0, 0, 4'b0000, 1, 4'b0000, 1, FAIR ? 2'd1 : 2'd0);
    // Reset mid-transfer
    add(0, 0, 4'b0010, 0, 4'b0010, 0, 0);
    add(1, 0, 4'b0010, 1, 4'b0000, 1, 1);
    add(0, 0, 4'b0110, 0, 4'b0010, 0, 0);
    add(0, 0, 4'b0000, 1, 4'b0000, 1, 1);
    add(0, 0, 4'b0000, 1, 4'b0000, 0, 0);

    // Two reset cycles with all requesters valid
    @(negedge clk); #1;
    chk("rst_ready_c0", 32'(ready), 32'h0);
    chk("rst_gvalid",   32'(gvalid), 32'h0);
    chk("rst_gdata",    gdata, 32'h0);
    chk("rst_gidx",     32'(gidx), 32'h0);
    chk("rst_u1_gvalid", 32'(u1_gvalid), 32'h0);
    @(negedge clk); #1;
    chk("rst_ready_c1", 32'(ready), 32'h0);

    foreach (tbl[n]) begin
      @(negedge clk);
      rst = tbl[n].rst; flush = tbl[n].flush; valid = tbl[n].valid; gready = tbl[n].gr;
      #1;
      chk($sformatf("row%0d_ready", n), 32'(ready), 32'(tbl[n].exp_rr));
      chk($sformatf("row%0d_gvalid", n), 32'(gvalid), 32'(tbl[n].exp_gv));
      if (tbl[n].exp_gv) begin
        chk($sformatf("row%0d_gidx", n), 32'(gidx), 32'(tbl[n].exp_idx));
        chk($sformatf("row%0d_gdata", n), gdata, dat[tbl[n].exp_idx]);
      end
    end

    // One-requester instance behaves as a pipeline register
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      rst = 1'b0; flush = 1'b0; valid = 4'b0000; gready = 1'b1;
      u1_valid = 1'b1; u1_data = 32'(k); u1_gready = 1'b1;
      #1;
      chk($sformatf("u1_k%0d_ready", k), 32'(u1_ready), 32'h1);
      chk($sformatf("u1_k%0d_gvalid", k), 32'(u1_gvalid), (k > 0) ? 32'h1 : 32'h0);
      if (k > 0) begin
        chk($sformatf("u1_k%0d_gdata", k), u1_gdata, 32'(k - 1));
        chk($sformatf("u1_k%0d_gidx", k), 32'(u1_gidx), 32'h0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
